// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory: port 0 is the LSU, port 1 the
// debug/loader/DMA master. Grants one access per cycle and registers per-port load responses.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ARB_MODE   = 0,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_m0_req,
   input  logic                  i_m0_we,
   input  logic [2:0]            i_m0_funct3,
   input  logic [ADDR_WIDTH-1:0] i_m0_addr,
   input  logic [DATA_WIDTH-1:0] i_m0_wdata,
   output logic                  o_m0_gnt,
   output logic                  o_m0_rvalid,
   output logic [DATA_WIDTH-1:0] o_m0_rdata,
   input  logic                  i_m1_req,
   input  logic                  i_m1_we,
   input  logic [2:0]            i_m1_funct3,
   input  logic [ADDR_WIDTH-1:0] i_m1_addr,
   input  logic [DATA_WIDTH-1:0] i_m1_wdata,
   output logic                  o_m1_gnt,
   output logic                  o_m1_rvalid,
   output logic [DATA_WIDTH-1:0] o_m1_rdata,
   output logic                  o_mem_wr_en,
   output logic [2:0]            o_mem_funct3,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

   localparam logic [3:0] WaitMax = 4'(MAX_WAIT);

   logic                  r_last_gnt;
   logic [3:0]            r_wait_cnt;
   logic                  r_rvalid0;
   logic                  r_rvalid1;
   logic [DATA_WIDTH-1:0] r_rdata0;
   logic [DATA_WIDTH-1:0] r_rdata1;

   logic w_pick1;
   logic w_gnt0;
   logic w_gnt1;

   // w_pick1 only matters on a tie; r_last_gnt = 1 means port 1 was granted last.
   always_comb begin
      if (ARB_MODE == 0) begin
         w_pick1 = (r_wait_cnt == WaitMax);
      end else begin
         w_pick1 = ~r_last_gnt;
      end
      w_gnt0 = i_rst_n & i_m0_req & ~(i_m1_req & w_pick1);
      w_gnt1 = i_rst_n & i_m1_req & ~(i_m0_req & ~w_pick1);
   end

   always_comb begin
      o_mem_wr_en  = 1'b0;
      o_mem_funct3 = 3'b010;
      o_mem_addr   = '0;
      o_mem_wdata  = '0;
      if (w_gnt0) begin
         o_mem_wr_en  = i_m0_we;
         o_mem_funct3 = i_m0_funct3;
         o_mem_addr   = i_m0_addr;
         o_mem_wdata  = i_m0_wdata;
      end else if (w_gnt1) begin
         o_mem_wr_en  = i_m1_we;
         o_mem_funct3 = i_m1_funct3;
         o_mem_addr   = i_m1_addr;
         o_mem_wdata  = i_m1_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_last_gnt <= 1'b1;
         r_wait_cnt <= 4'd0;
         r_rvalid0  <= 1'b0;
         r_rvalid1  <= 1'b0;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
      end else begin
         if (w_gnt0) begin
            r_last_gnt <= 1'b0;
         end else if (w_gnt1) begin
            r_last_gnt <= 1'b1;
         end
         if (i_m1_req && !w_gnt1) begin
            if (r_wait_cnt < WaitMax) begin
               r_wait_cnt <= r_wait_cnt + 4'd1;
            end
         end else begin
            r_wait_cnt <= 4'd0;
         end
         r_rvalid0 <= w_gnt0 & ~i_m0_we;
         r_rvalid1 <= w_gnt1 & ~i_m1_we;
         if (w_gnt0 && !i_m0_we) begin
            r_rdata0 <= i_mem_rdata;
         end
         if (w_gnt1 && !i_m1_we) begin
            r_rdata1 <= i_mem_rdata;
         end
      end
   end

   // Responses are masked while reset is held so a load granted just before reset never shows.
   assign o_m0_gnt    = w_gnt0;
   assign o_m1_gnt    = w_gnt1;
   assign o_m0_rvalid = r_rvalid0 & i_rst_n;
   assign o_m1_rvalid = r_rvalid1 & i_rst_n;
   assign o_m0_rdata  = i_rst_n ? r_rdata0 : '0;
   assign o_m1_rdata  = i_rst_n ? r_rdata1 : '0;

endmodule
